alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//   Registered output stage directly downstream of the combinational BreadBoard ALU.
//   Captures R/error/op_code through a valid/ready handshake and presents them one cycle
//   later to the consumer. Keeps a sticky error flag and a wrapping count of accepted results.
//   Drives the 4-digit multiplexed seven-segment display from the last accepted result.
// PARAMETERS
//   DATA_W    32  width of the result bus; matches ALU R
//   SCAN_DIV  16  clk cycles each display digit stays enabled; must be >= 2
//   CNT_W     16  width of result_count
// PORTS
//   clk           in   1       rising-edge clock
//   rst           in   1       asynchronous, active-high reset
//   in_valid      in   1       ALU result on in_result/in_error/in_op_code is valid
//   in_ready      out  1       stage can accept this cycle
//   in_result     in   DATA_W  ALU R
//   in_error      in   1       ALU error (add/sub overflow)
//   in_op_code    in   4       op_code that produced in_result
//   out_valid     out  1       registered result available
//   out_ready     in   1       consumer takes the result this cycle
//   out_result    out  DATA_W  registered result
//   out_error     out  1       registered error (see BEHAVIOUR)
//   out_op_code   out  4       registered op_code
//   err_clear     in   1       clears err_sticky
//   err_sticky    out  1       set by any accepted result with out_error semantics = 1
//   result_count  out  CNT_W   number of accepted results, mod 2^CNT_W
//   seg           out  7       segments {g,f,e,d,c,b,a}, active-high
//   digit_en      out  4       one-hot digit enable, active-high, bit0 = least significant hex digit
// BEHAVIOUR
//   Reset (async, immediate): out_valid=0, out_result=0, out_error=0, out_op_code=0,
//     err_sticky=0, result_count=0, display hold=0, prescaler=0, digit index=0
//     -> digit_en=4'b0001, seg=7'h3F. A result held or in flight is discarded; no handshake completes.
//   Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
//     Accept loads out_* on the next edge and sets out_valid. Latency 1 cycle.
//     out_valid clears on out_ready & !accept. Simultaneous drain + accept gives back-to-back
//     throughput of 1/cycle with no bubble. Held out_* stay stable while out_valid & !out_ready.
//   Error: the registered error = in_error | unsupported op.
//     Supported op codes: 0 (add), 1 (mod), 2 (div), 4 (mult), 8 (sub).
//     Any other op code is flagged unsupported; in_result is still passed through unchanged.
//     err_sticky is set on accept with that error = 1 and cleared on err_clear.
//     Set and clear in the same cycle: set wins.
//   Counter: result_count += 1 per accept. 0xFFFF wraps to 0x0000; there is no saturation.
//   Display hold: on accept, latch in_result[15:0]. Nothing else changes it.
//   Prescaler: counts 0..SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and the digit index
//     advances 0->1->2->3->0. digit_en = 1 << index.
//   seg, combinational from index and state:
//     - normal: hex glyph of hold[4*index+3 : 4*index].
//     - while err_sticky=1: all digits show 'E' (7'h79).
//   Hex glyphs (gfedcba):
//     0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07,
//     8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
// TESTING
//   1. Reset mid-hold: accept R=15, assert rst -> out_valid=0, count=0, seg=3F, digit_en=0001.
//   2. Throughput: out_ready=1, in_valid=1 for 5 cycles with R=1..5 -> out_result=1..5 on
//      consecutive cycles, in_ready stays 1, count=5.
//   3. Backpressure: out_ready=0, accept R=0x1234 -> in_ready=0, second value blocked,
//      out_result holds 0x1234; out_ready=1 -> the second value appears on the next cycle.
//   4. Errors: accept op=8 with in_error=1 -> out_error=1, err_sticky=1, all digits 79.
//      Then err_clear together with an accept of op=3 -> err_sticky stays 1 (unsupported op, set wins).
//   5. Counter wrap: preload via 65535 accepts, one more accept -> result_count=0x0000.
//   6. Display scan: hold=0xA5C3, SCAN_DIV=16 -> digit_en advances every 16 clk.
//      seg sequence 39, 77(wait: digit1=C->39), checked per digit: d0=4F, d1=39, d2=6D, d3=77.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage behind the BreadBoard ALU: valid/ready capture, sticky error,
// accepted-result counter and a 4-digit multiplexed seven-segment driver.
module alu_result_stage #(
    parameter int DATA_W   = 32,
    parameter int SCAN_DIV = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_error,
    input  logic [3:0]        in_op_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_error,
    output logic [3:0]        out_op_code,
    input  logic              err_clear,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  result_count,
    output logic [6:0]        seg,
    output logic [3:0]        digit_en
);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_result_reg;
    logic              out_error_reg;
    logic [3:0]        out_op_code_reg;
    logic              err_sticky_reg;
    logic [CNT_W-1:0]  result_count_reg;
    logic [15:0]       hold_reg;
    logic [PRE_W-1:0]  prescaler_reg;
    logic [1:0]        digit_idx_reg;

    logic       accept;
    logic       op_supported;
    logic       err_next;
    logic [3:0] nibble;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_supported = 1'b0;
        case (in_op_code)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd8: op_supported = 1'b1;
            default:                      op_supported = 1'b0;
        endcase
    end

    // Unsupported op codes still pass their result through, but are reported as errors.
    assign err_next = in_error || !op_supported;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            out_result_reg   <= '0;
            out_error_reg    <= 1'b0;
            out_op_code_reg  <= 4'd0;
            err_sticky_reg   <= 1'b0;
            result_count_reg <= '0;
            hold_reg         <= 16'd0;
            prescaler_reg    <= '0;
            digit_idx_reg    <= 2'd0;
        end else begin
            if (accept) begin
                out_valid_reg    <= 1'b1;
                out_result_reg   <= in_result;
                out_error_reg    <= err_next;
                out_op_code_reg  <= in_op_code;
                result_count_reg <= result_count_reg + CNT_W'(1);
                hold_reg         <= in_result[15:0];
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end

            // A new error outranks a simultaneous clear request.
            if (accept && err_next)
                err_sticky_reg <= 1'b1;
            else if (err_clear)
                err_sticky_reg <= 1'b0;

            if (prescaler_reg == PRE_LAST) begin
                prescaler_reg <= '0;
                digit_idx_reg <= digit_idx_reg + 2'd1;
            end else begin
                prescaler_reg <= prescaler_reg + PRE_W'(1);
            end
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    assign nibble = hold_reg[{digit_idx_reg, 2'b00} +: 4];
    assign seg    = err_sticky_reg ? 7'h79 : hex_glyph(nibble);

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_en
        assign digit_en[gi] = (digit_idx_reg == 2'(gi));
    end

    assign out_valid    = out_valid_reg;
    assign out_result   = out_result_reg;
    assign out_error    = out_error_reg;
    assign out_op_code  = out_op_code_reg;
    assign err_sticky   = err_sticky_reg;
    assign result_count = result_count_reg;
endmodule
